// File: rtl/cr_huf_comp_stcl_packer_if.sv
// LUT write port: one OUT_WIDTH-bit word plus its address, with a valid/ready handshake.
interface cr_huf_comp_stcl_packer_if #(
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  wr_valid;
  logic [OUT_WIDTH-1:0]  wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_ready;

  modport master (output wr_valid, output wr_data, output wr_addr, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_addr, output wr_ready);
endinterface

// File: rtl/cr_huf_comp_stcl_packer.sv
// Small-table code-length packer: snapshots NUM_SYM code lengths, encodes them (raw/delta/deflate)
// and streams the bit string LSB-first as OUT_WIDTH-bit LUT words with full backpressure.
module cr_huf_comp_stcl_packer #(
  parameter int NUM_SYM    = 33,
  parameter int CL_WIDTH   = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int SIZE_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_SYM*CL_WIDTH-1:0] cl_vec,
  cr_huf_comp_stcl_packer_if.master   wr,
  output logic                        done,
  output logic [SIZE_WIDTH-1:0]       stcl_size,
  output logic [4:0]                  hclen,
  output logic                        busy
);

  localparam int PAD_SYM = (NUM_SYM < 19) ? 19 : NUM_SYM;
  localparam int IW      = $clog2(PAD_SYM);
  localparam int PW      = $clog2(PAD_SYM + 1);
  localparam int AW      = OUT_WIDTH + CL_WIDTH;
  localparam int BW      = $clog2(AW + 1);

  localparam logic [1:0] M_RAW   = 2'd0;
  localparam logic [1:0] M_DELTA = 2'd1;
  localparam logic [1:0] M_DEFL  = 2'd2;

  typedef enum logic [1:0] {IDLE, BUILD, FLUSH} state_t;

  state_t                state;
  logic [1:0]            mode_q;
  logic [CL_WIDTH-1:0]   cl_snap [PAD_SYM];
  logic [CL_WIDTH-1:0]   cl_in   [PAD_SYM];
  logic [PAD_SYM*CL_WIDTH-1:0] cl_wide;
  logic [CL_WIDTH-1:0]   prev;
  logic [PW-1:0]         sym_ptr;
  logic [PW-1:0]         n_sym;
  logic [AW-1:0]         acc;
  logic [BW-1:0]         bitcnt;
  logic [4:0]            defl_cnt;
  logic [IW-1:0]         sym_idx;
  logic [CL_WIDTH-1:0]   cl_cur;
  logic [CL_WIDTH-1:0]   cl_m1;
  logic [AW-1:0]         enc_val;
  logic [BW-1:0]         enc_len;
  logic                  full;
  logic                  slot_free;
  logic                  accept;
  logic                  emit;
  logic                  consume;

  function automatic logic [IW-1:0] defl_order(input logic [4:0] k);
    case (k)
      5'd0:  return IW'(16);
      5'd1:  return IW'(17);
      5'd2:  return IW'(18);
      5'd3:  return IW'(0);
      5'd4:  return IW'(8);
      5'd5:  return IW'(7);
      5'd6:  return IW'(9);
      5'd7:  return IW'(6);
      5'd8:  return IW'(10);
      5'd9:  return IW'(5);
      5'd10: return IW'(11);
      5'd11: return IW'(4);
      5'd12: return IW'(12);
      5'd13: return IW'(3);
      5'd14: return IW'(13);
      5'd15: return IW'(2);
      5'd16: return IW'(14);
      5'd17: return IW'(1);
      5'd18: return IW'(15);
      default: return IW'(0);
    endcase
  endfunction

  // Zero-extend to at least 19 symbols so the deflate permutation never indexes past the vector.
  assign cl_wide = (PAD_SYM*CL_WIDTH)'(cl_vec);

  always_comb begin
    for (int i = 0; i < PAD_SYM; i++) cl_in[i] = cl_wide[i*CL_WIDTH +: CL_WIDTH];
  end

  always_comb begin
    defl_cnt = 5'd4;
    for (int k = 4; k < 19; k++)
      if (cl_in[defl_order(5'(k))] != '0) defl_cnt = 5'(k + 1);
  end

  always_comb begin
    sym_idx = (mode_q == M_DEFL) ? defl_order(5'(sym_ptr)) : IW'(sym_ptr);
    cl_cur  = cl_snap[sym_idx];
    cl_m1   = cl_cur - CL_WIDTH'(1);
    enc_val = '0;
    enc_len = BW'(CL_WIDTH);
    case (mode_q)
      M_DELTA: begin
        enc_len = BW'(4);
        if (cl_cur == prev) begin
          enc_len = BW'(1);
        end else if (cl_cur > prev) begin
          enc_val = AW'({cl_m1[2:0], 1'b1});
        end else begin
          enc_val = AW'({cl_cur[2:0], 1'b1});
        end
      end
      M_DEFL: begin
        enc_val = AW'(cl_cur[2:0]);
        enc_len = BW'(3);
      end
      default: enc_val = AW'(cl_cur);
    endcase
  end

  assign full      = (bitcnt >= BW'(OUT_WIDTH));
  assign slot_free = !wr.wr_valid || wr.wr_ready;
  assign accept    = wr.wr_valid && wr.wr_ready;
  assign emit      = slot_free && (((state == BUILD) && full) || ((state == FLUSH) && (bitcnt != '0)));
  // Consuming only below OUT_WIDTH bits caps the accumulator at OUT_WIDTH+CL_WIDTH-1 bits.
  assign consume   = (state == BUILD) && !full;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= M_RAW;
      cl_snap     <= '{default: '0};
      prev        <= '0;
      sym_ptr     <= '0;
      n_sym       <= '0;
      acc         <= '0;
      bitcnt      <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_data  <= '0;
      wr.wr_addr  <= '0;
      done        <= 1'b0;
      stcl_size   <= '0;
      hclen       <= '0;
    end else if (abort) begin
      state       <= IDLE;
      wr.wr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) wr.wr_addr <= wr.wr_addr + ADDR_WIDTH'(1);

      if (emit) begin
        wr.wr_valid <= 1'b1;
        wr.wr_data  <= acc[OUT_WIDTH-1:0];
        acc         <= acc >> OUT_WIDTH;
        bitcnt      <= full ? (bitcnt - BW'(OUT_WIDTH)) : '0;
      end else if (accept) begin
        wr.wr_valid <= 1'b0;
      end

      if (consume) begin
        acc       <= acc | (enc_val << bitcnt);
        bitcnt    <= bitcnt + enc_len;
        stcl_size <= stcl_size + SIZE_WIDTH'(enc_len);
        prev      <= cl_cur;
        sym_ptr   <= sym_ptr + PW'(1);
        if (sym_ptr == n_sym - PW'(1)) state <= FLUSH;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= BUILD;
            cl_snap    <= cl_in;
            mode_q     <= (mode == 2'd3) ? M_RAW : mode;
            prev       <= CL_WIDTH'(4);
            sym_ptr    <= '0;
            acc        <= '0;
            bitcnt     <= '0;
            stcl_size  <= '0;
            wr.wr_addr <= '0;
            hclen      <= (mode == M_DEFL) ? (defl_cnt - 5'd4) : 5'd0;
            n_sym      <= (mode == M_DEFL) ? PW'(defl_cnt) : PW'(NUM_SYM);
          end
        end
        FLUSH: begin
          if ((bitcnt == '0) && (accept || !wr.wr_valid)) begin
            state       <= IDLE;
            wr.wr_valid <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_huf_comp_stcl_packer.sv
// Directed bench: three packer configurations (delta 4x4->8, deflate 19x4->8, raw 8x4->16).
module tb_cr_huf_comp_stcl_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [1:0]  mode_d = 2'd1, mode_f = 2'd2, mode_r = 2'd0;
  logic        start_d = 0, start_f = 0, start_r = 0;
  logic        abort_d = 0, abort_f = 0, abort_r = 0;
  logic [15:0] cl_d = '0;
  logic [75:0] cl_f = '0;
  logic [31:0] cl_r = '0;
  logic        done_d, done_f, done_r, busy_d, busy_f, busy_r;
  logic [9:0]  size_d, size_f, size_r;
  logic [4:0]  hclen_d, hclen_f, hclen_r;

  cr_huf_comp_stcl_packer_if #(.OUT_WIDTH(8),  .ADDR_WIDTH(6)) wr_d();
  cr_huf_comp_stcl_packer_if #(.OUT_WIDTH(8),  .ADDR_WIDTH(6)) wr_f();
  cr_huf_comp_stcl_packer_if #(.OUT_WIDTH(16), .ADDR_WIDTH(6)) wr_r();

  cr_huf_comp_stcl_packer #(.NUM_SYM(4), .CL_WIDTH(4), .OUT_WIDTH(8), .ADDR_WIDTH(6), .SIZE_WIDTH(10)) u_d (
    .clk(clk), .rst_n(rst_n), .mode(mode_d), .start(start_d), .abort(abort_d), .cl_vec(cl_d),
    .wr(wr_d), .done(done_d), .stcl_size(size_d), .hclen(hclen_d), .busy(busy_d));
  cr_huf_comp_stcl_packer #(.NUM_SYM(19), .CL_WIDTH(4), .OUT_WIDTH(8), .ADDR_WIDTH(6), .SIZE_WIDTH(10)) u_f (
    .clk(clk), .rst_n(rst_n), .mode(mode_f), .start(start_f), .abort(abort_f), .cl_vec(cl_f),
    .wr(wr_f), .done(done_f), .stcl_size(size_f), .hclen(hclen_f), .busy(busy_f));
  cr_huf_comp_stcl_packer #(.NUM_SYM(8), .CL_WIDTH(4), .OUT_WIDTH(16), .ADDR_WIDTH(6), .SIZE_WIDTH(10)) u_r (
    .clk(clk), .rst_n(rst_n), .mode(mode_r), .start(start_r), .abort(abort_r), .cl_vec(cl_r),
    .wr(wr_r), .done(done_r), .stcl_size(size_r), .hclen(hclen_r), .busy(busy_r));

  logic [15:0] qd_data[$], qf_data[$], qr_data[$];
  logic [5:0]  qd_addr[$], qf_addr[$], qr_addr[$];
  int nd_done = 0, nf_done = 0, nr_done = 0;
  int r_words_at_done = 0;

  always @(negedge clk) begin
    if (wr_d.wr_valid && wr_d.wr_ready) begin qd_data.push_back(16'(wr_d.wr_data)); qd_addr.push_back(wr_d.wr_addr); end
    if (wr_f.wr_valid && wr_f.wr_ready) begin qf_data.push_back(16'(wr_f.wr_data)); qf_addr.push_back(wr_f.wr_addr); end
    if (wr_r.wr_valid && wr_r.wr_ready) begin qr_data.push_back(wr_r.wr_data); qr_addr.push_back(wr_r.wr_addr); end
    if (done_d) nd_done++;
    if (done_f) nf_done++;
    if (done_r) begin nr_done++; r_words_at_done = qr_data.size(); end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (wr_d.wr_valid !== 1'b0) $display("FAIL rst_valid_d: got %0b want 0", wr_d.wr_valid); else passed++;
    checks++; if (wr_r.wr_data !== 16'h0) $display("FAIL rst_data_r: got %0h want 0", wr_r.wr_data); else passed++;
    checks++; if (wr_f.wr_addr !== 6'h0) $display("FAIL rst_addr_f: got %0h want 0", wr_f.wr_addr); else passed++;
    checks++; if ({done_d, done_f, done_r} !== 3'b0) $display("FAIL rst_done: got %0b want 0", {done_d, done_f, done_r}); else passed++;
    checks++; if ({busy_d, busy_f, busy_r} !== 3'b0) $display("FAIL rst_busy: got %0b want 0", {busy_d, busy_f, busy_r}); else passed++;
    checks++; if (size_f !== 10'd0 || hclen_f !== 5'd0) $display("FAIL rst_size_hclen: got %0d/%0d want 0/0", size_f, hclen_f); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_d.wr_ready = 1'b1; wr_f.wr_ready = 1'b1; wr_r.wr_ready = 1'b1;
    tick();
  endtask

  task automatic test_delta_basic();
    int b = qd_data.size();
    int bd = nd_done;
    mode_d = 2'd1; cl_d = 16'h0355; start_d = 1'b1; tick(); start_d = 1'b0;
    for (int i = 0; i < 60 && nd_done == bd; i++) tick();
    repeat (3) tick();
    checks++; if (nd_done - bd !== 1) $display("FAIL delta_done_pulses: got %0d want 1", nd_done - bd); else passed++;
    checks++; if (qd_data.size() - b !== 2) $display("FAIL delta_word_count: got %0d want 2", qd_data.size() - b); else passed++;
    if (qd_data.size() >= b + 2) begin
      checks++; if (qd_data[b] !== 16'hE9 || qd_addr[b] !== 6'd0) $display("FAIL delta_word0: got %0h@%0d want e9@0", qd_data[b], qd_addr[b]); else passed++;
      checks++; if (qd_data[b+1] !== 16'h02 || qd_addr[b+1] !== 6'd1) $display("FAIL delta_word1: got %0h@%0d want 2@1", qd_data[b+1], qd_addr[b+1]); else passed++;
    end
    checks++; if (size_d !== 10'd13) $display("FAIL delta_size: got %0d want 13", size_d); else passed++;
    checks++; if (hclen_d !== 5'd0) $display("FAIL delta_hclen: got %0d want 0", hclen_d); else passed++;
    checks++; if (busy_d !== 1'b0) $display("FAIL delta_busy_end: got %0b want 0", busy_d); else passed++;
  endtask

  task automatic test_delta_equal();
    int b = qd_data.size();
    int bd = nd_done;
    mode_d = 2'd1; cl_d = 16'h4444; start_d = 1'b1; tick(); start_d = 1'b0;
    for (int i = 0; i < 60 && nd_done == bd; i++) tick();
    tick();
    checks++; if (nd_done - bd !== 1) $display("FAIL equal_done: got %0d want 1", nd_done - bd); else passed++;
    checks++; if (qd_data.size() - b !== 1) $display("FAIL equal_word_count: got %0d want 1", qd_data.size() - b); else passed++;
    if (qd_data.size() >= b + 1) begin
      checks++; if (qd_data[b] !== 16'h00 || qd_addr[b] !== 6'd0) $display("FAIL equal_word0: got %0h@%0d want 0@0", qd_data[b], qd_addr[b]); else passed++;
    end
    checks++; if (size_d !== 10'd4) $display("FAIL equal_size: got %0d want 4", size_d); else passed++;
  endtask

  task automatic test_start_ignored();
    int b = qd_data.size();
    int bd = nd_done;
    mode_d = 2'd1; cl_d = 16'h0355; start_d = 1'b1; tick();
    cl_d = 16'h4444; mode_d = 2'd0; tick(); start_d = 1'b0;
    checks++; if (busy_d !== 1'b1) $display("FAIL ignored_busy: got %0b want 1", busy_d); else passed++;
    for (int i = 0; i < 60 && nd_done == bd; i++) tick();
    tick();
    checks++; if (nd_done - bd !== 1) $display("FAIL ignored_done: got %0d want 1", nd_done - bd); else passed++;
    checks++; if (qd_data.size() - b !== 2) $display("FAIL ignored_word_count: got %0d want 2", qd_data.size() - b); else passed++;
    if (qd_data.size() >= b + 2) begin
      checks++; if (qd_data[b] !== 16'hE9 || qd_data[b+1] !== 16'h02) $display("FAIL ignored_words: got %0h,%0h want e9,2", qd_data[b], qd_data[b+1]); else passed++;
    end
    checks++; if (size_d !== 10'd13) $display("FAIL ignored_size: got %0d want 13", size_d); else passed++;
  endtask

  task automatic test_deflate();
    logic [7:0] exp8 [8];
    int b = qf_data.size();
    int bd = nf_done;
    exp8 = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00};
    mode_f = 2'd2; cl_f = '0; cl_f[16*4 +: 4] = 4'd3; start_f = 1'b1; tick(); start_f = 1'b0;
    for (int i = 0; i < 80 && nf_done == bd; i++) tick();
    tick();
    checks++; if (nf_done - bd !== 1) $display("FAIL defl4_done: got %0d want 1", nf_done - bd); else passed++;
    checks++; if (qf_data.size() - b !== 2) $display("FAIL defl4_word_count: got %0d want 2", qf_data.size() - b); else passed++;
    if (qf_data.size() >= b + 2) begin
      checks++; if (qf_data[b] !== 16'h03 || qf_data[b+1] !== 16'h00) $display("FAIL defl4_words: got %0h,%0h want 3,0", qf_data[b], qf_data[b+1]); else passed++;
    end
    checks++; if (size_f !== 10'd12 || hclen_f !== 5'd0) $display("FAIL defl4_size_hclen: got %0d/%0d want 12/0", size_f, hclen_f); else passed++;

    b = qf_data.size(); bd = nf_done;
    cl_f[15*4 +: 4] = 4'd1; start_f = 1'b1; tick(); start_f = 1'b0;
    for (int i = 0; i < 120 && nf_done == bd; i++) tick();
    tick();
    checks++; if (nf_done - bd !== 1) $display("FAIL defl19_done: got %0d want 1", nf_done - bd); else passed++;
    checks++; if (qf_data.size() - b !== 8) $display("FAIL defl19_word_count: got %0d want 8", qf_data.size() - b); else passed++;
    if (qf_data.size() >= b + 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (qf_data[b+i] !== 16'(exp8[i]) || qf_addr[b+i] !== 6'(i))
          $display("FAIL defl19_word%0d: got %0h@%0d want %0h@%0d", i, qf_data[b+i], qf_addr[b+i], exp8[i], i);
        else passed++;
      end
    end
    checks++; if (size_f !== 10'd57 || hclen_f !== 5'd15) $display("FAIL defl19_size_hclen: got %0d/%0d want 57/15", size_f, hclen_f); else passed++;
  endtask

  task automatic test_backpressure();
    int b = qr_data.size();
    int bd = nr_done;
    wr_r.wr_ready = 1'b0; mode_r = 2'd0; cl_r = 32'h76543210; start_r = 1'b1; tick(); start_r = 1'b0;
    for (int i = 0; i < 30 && !wr_r.wr_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_r.wr_valid !== 1'b1 || wr_r.wr_data !== 16'h3210 || wr_r.wr_addr !== 6'd0)
        $display("FAIL bp_hold%0d: got v=%0b %0h@%0d want v=1 3210@0", i, wr_r.wr_valid, wr_r.wr_data, wr_r.wr_addr);
      else passed++;
      tick();
    end
    checks++; if (nr_done !== bd) $display("FAIL bp_early_done: got %0d want %0d", nr_done, bd); else passed++;
    wr_r.wr_ready = 1'b1;
    for (int i = 0; i < 30 && nr_done == bd; i++) tick();
    tick();
    checks++; if (nr_done - bd !== 1) $display("FAIL bp_done: got %0d want 1", nr_done - bd); else passed++;
    checks++; if (r_words_at_done - b !== 2) $display("FAIL bp_words_before_done: got %0d want 2", r_words_at_done - b); else passed++;
    if (qr_data.size() >= b + 2) begin
      checks++; if (qr_data[b] !== 16'h3210 || qr_addr[b] !== 6'd0) $display("FAIL bp_word0: got %0h@%0d want 3210@0", qr_data[b], qr_addr[b]); else passed++;
      checks++; if (qr_data[b+1] !== 16'h7654 || qr_addr[b+1] !== 6'd1) $display("FAIL bp_word1: got %0h@%0d want 7654@1", qr_data[b+1], qr_addr[b+1]); else passed++;
    end
    checks++; if (size_r !== 10'd32 || hclen_r !== 5'd0) $display("FAIL bp_size_hclen: got %0d/%0d want 32/0", size_r, hclen_r); else passed++;
  endtask

  task automatic test_abort();
    int b;
    int bd = nr_done;
    wr_r.wr_ready = 1'b0; mode_r = 2'd0; cl_r = 32'h76543210; start_r = 1'b1; tick(); start_r = 1'b0;
    for (int i = 0; i < 30 && !wr_r.wr_valid; i++) tick();
    abort_r = 1'b1; tick(); abort_r = 1'b0;
    checks++; if (wr_r.wr_valid !== 1'b0 || busy_r !== 1'b0) $display("FAIL abort_idle: got v=%0b busy=%0b want 0/0", wr_r.wr_valid, busy_r); else passed++;
    repeat (4) tick();
    checks++; if (nr_done !== bd) $display("FAIL abort_no_done: got %0d want %0d", nr_done, bd); else passed++;
    b = qr_data.size();
    wr_r.wr_ready = 1'b1; cl_r = 32'hFEDCBA98; start_r = 1'b1; tick(); start_r = 1'b0;
    for (int i = 0; i < 30 && nr_done == bd; i++) tick();
    tick();
    checks++; if (nr_done - bd !== 1) $display("FAIL abort_restart_done: got %0d want 1", nr_done - bd); else passed++;
    if (qr_data.size() >= b + 2) begin
      checks++; if (qr_data[b] !== 16'hBA98 || qr_addr[b] !== 6'd0) $display("FAIL abort_restart_word0: got %0h@%0d want ba98@0", qr_data[b], qr_addr[b]); else passed++;
      checks++; if (qr_data[b+1] !== 16'hFEDC || qr_addr[b+1] !== 6'd1) $display("FAIL abort_restart_word1: got %0h@%0d want fedc@1", qr_data[b+1], qr_addr[b+1]); else passed++;
    end else begin
      checks++; $display("FAIL abort_restart_count: got %0d want 2", qr_data.size() - b);
    end
  endtask

  task automatic test_reset_mid();
    wr_r.wr_ready = 1'b0; mode_r = 2'd0; cl_r = 32'h76543210; start_r = 1'b1; tick(); start_r = 1'b0;
    for (int i = 0; i < 30 && !wr_r.wr_valid; i++) tick();
    checks++; if (wr_r.wr_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %0b want 1", wr_r.wr_valid); else passed++;
    rst_n = 1'b0; #1;
    checks++; if (wr_r.wr_valid !== 1'b0 || busy_r !== 1'b0 || wr_r.wr_data !== 16'h0) $display("FAIL midrst_outputs: got v=%0b busy=%0b d=%0h want 0", wr_r.wr_valid, busy_r, wr_r.wr_data); else passed++;
    checks++; if (size_r !== 10'd0 || wr_r.wr_addr !== 6'd0) $display("FAIL midrst_size_addr: got %0d/%0d want 0/0", size_r, wr_r.wr_addr); else passed++;
    tick(); rst_n = 1'b1; wr_r.wr_ready = 1'b1; tick();
  endtask

  initial begin
    wr_d.wr_ready = 1'b0; wr_f.wr_ready = 1'b0; wr_r.wr_ready = 1'b0;
    test_reset();
    test_delta_basic();
    test_delta_equal();
    test_start_ignored();
    test_deflate();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
